// File: rtl/conv_window_ctrl.sv
// Line-buffered 3x3 window sequencer for the convolution MAC stage.
// Four rotating line buffers; three full lines are streamed as windows while the fourth fills.
//
// state  | meaning
// S_IDLE | waiting for three complete unretired lines
// S_RD   | issuing one 3x3 window per cycle across the oldest three lines
module conv_window_ctrl #(
   parameter int IMG_WIDTH = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_pixel_data,
   input  logic        i_pixel_data_valid,
   output logic [71:0] o_pixel_data,
   output logic        o_pixel_data_valid,
   output logic        o_intr
);

   localparam int NUM_BUF = 4;
   localparam int PW      = $clog2(IMG_WIDTH);
   localparam int TW      = $clog2(NUM_BUF*IMG_WIDTH + 1);

   localparam logic [PW-1:0] LAST_WR  = PW'(IMG_WIDTH - 1);
   localparam logic [PW-1:0] LAST_RD  = PW'(IMG_WIDTH - 3);
   localparam logic [TW-1:0] TOT_FULL = TW'(NUM_BUF*IMG_WIDTH);
   localparam logic [TW-1:0] TOT_RDY  = TW'(3*IMG_WIDTH);
   localparam logic [TW-1:0] TOT_LINE = TW'(IMG_WIDTH);

   typedef enum logic {S_IDLE, S_RD} state_t;

   logic [7:0]    r_buf [NUM_BUF][IMG_WIDTH];
   logic [PW-1:0] r_wr_ptr;
   logic [1:0]    r_wr_sel;
   logic [PW-1:0] r_rd_ptr;
   logic [1:0]    r_rd_sel;
   logic [TW-1:0] r_total;
   state_t        r_state;
   logic [71:0]   r_data;
   logic          r_valid;
   logic          r_intr;

   state_t        w_state_nxt;
   logic          w_issue;
   logic          w_retire;
   logic          w_wr_en;
   logic [71:0]   w_window;

   // Full-buffer guard: the only case where wr_sel could alias the top read line.
   assign w_wr_en = i_pixel_data_valid && (r_total < TOT_FULL);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_buf[r_wr_sel][r_wr_ptr] <= i_pixel_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_wr_sel <= '0;
      end else if (w_wr_en) begin
         if (r_wr_ptr == LAST_WR) begin
            r_wr_ptr <= '0;
            r_wr_sel <= r_wr_sel + 2'd1;
         end else begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total <= '0;
      end else begin
         r_total <= r_total + TW'(w_wr_en) - (w_retire ? TOT_LINE : TW'(0));
      end
   end

   always_comb begin
      w_window = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_window[(r*3 + c)*8 +: 8] = r_buf[r_rd_sel + 2'(r)][r_rd_ptr + PW'(c)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_total >= TOT_RDY) begin
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            w_issue = 1'b1;
            if (r_rd_ptr == LAST_RD) begin
               w_retire    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_rd_sel <= '0;
      end else if (w_retire) begin
         r_rd_ptr <= '0;
         r_rd_sel <= r_rd_sel + 2'd1;
      end else if (w_issue) begin
         r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Data holds its last window between lines; only valid qualifies it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_intr  <= 1'b0;
      end else begin
         if (w_issue) begin
            r_data <= w_window;
         end
         r_valid <= w_issue;
         r_intr  <= w_retire;
      end
   end

   assign o_pixel_data       = r_data;
   assign o_pixel_data_valid = r_valid;
   assign o_intr             = r_intr;

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer that feeds the 3x3 MAC stage of the 2-D convolution pipeline. It accepts a raster stream of 8-bit pixels and stores lines in four rotating line buffers. Once three complete lines are held, it issues one 72-bit 3x3 window per clock to the MAC, retires the oldest line, and pulses an interrupt so the upstream source can deliver the next line.

## Interface
- `IMG_WIDTH`, default 512: pixels per image line; minimum 4.
- `NUM_BUF`, fixed 4: line buffers; not user-changeable.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_pixel_data`  in  8  incoming pixel, raster order.
- `i_pixel_data_valid`  in  1  qualifies `i_pixel_data`; one pixel per asserted cycle; no backpressure.
- `o_pixel_data`  out  72  3x3 window to the MAC; byte k = `o_pixel_data[k*8+:8]`.
- `o_pixel_data_valid`  out  1  qualifies `o_pixel_data`.
- `o_intr`  out  1  one-cycle pulse: a line was retired and a buffer is free.

## Operation
- Storage: 4 buffers of `IMG_WIDTH` x 8 bits.
- Write side: `wr_ptr` (column) and `wr_sel` (buffer, mod 4).
  - Each valid pixel is written to `buf[wr_sel][wr_ptr]`, then `wr_ptr` increments.
  - At `IMG_WIDTH-1`, `wr_ptr` wraps to 0 and `wr_sel` increments mod 4.
- Fill count: `total` (0..4*`IMG_WIDTH`) counts stored, unretired pixels.
  - Update each edge: `total` + accepted_write − (retire ? `IMG_WIDTH` : 0).
  - A write is accepted only if pre-update `total` < 4*`IMG_WIDTH`. Otherwise the pixel is dropped and the pointers hold. This is a guard only; it cannot trigger with one pixel per cycle.
- Read side: `rd_sel` (oldest line) and `rd_ptr` (window left column).
  - Top line = `rd_sel`, middle = `rd_sel+1`, bottom = `rd_sel+2`, all mod 4.
- Window packing, columns c, c+1, c+2 with c = `rd_ptr`:
  - Bytes 0-2 = top line, columns c..c+2.
  - Bytes 3-5 = middle line, columns c..c+2.
  - Bytes 6-8 = bottom line, columns c..c+2.
- Only valid (non-padded) windows are produced: `IMG_WIDTH-2` windows per line, c = 0..`IMG_WIDTH-3`.
- FSM:
  - `IDLE`: go to `RD` when registered `total` >= 3*`IMG_WIDTH`; otherwise stay.
  - `RD`: each cycle, register the window at `rd_ptr` and assert valid, then `rd_ptr` increments.
  - When the window at `rd_ptr` = `IMG_WIDTH-3` is issued: `rd_ptr` ← 0, `rd_sel` increments mod 4, retire (`total` −= `IMG_WIDTH`), pulse `o_intr`, go to `IDLE`.
- A simultaneous write and retire in the same cycle both apply.
- The write buffer never aliases a line being read: `wr_sel` equals the top-line buffer only when `total` is full, and the write is then dropped.

## Timing
- Reset values: `o_pixel_data` = 0, `o_pixel_data_valid` = 0, `o_intr` = 0, all pointers and `total` = 0, FSM = `IDLE`. Buffer contents are don't-care.
- Reset asserted mid-line or mid-`RD` aborts immediately. After release, the block behaves as freshly powered up; partial lines are discarded.
- Write latency: a pixel is stored on the edge where `i_pixel_data_valid` = 1.
- First window: `o_pixel_data_valid` rises after the 2nd edge following the edge that stores pixel 3*`IMG_WIDTH`.
  - Edge +1: `IDLE`→`RD`.
  - Edge +2: window 0 registered.
- Per line: `IMG_WIDTH-2` consecutive valid cycles. `o_intr` = 1 in the same cycle as the last window of the line.
- Back-to-back lines: one bubble cycle (valid = 0) between lines, spent in `IDLE`.
- Sustained throughput: `IMG_WIDTH-2` windows per `IMG_WIDTH-1` cycles. This exceeds the input line rate, so buffers never fill under a continuous stream.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset check, `IMG_WIDTH`=8: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; no valid output while held.
- `IMG_WIDTH`=8, write pixels 1..24 continuously:
  - 6 valid windows, first beginning 2 edges after pixel 24.
  - First window = 72'h13_12_11_0B_0A_09_03_02_01.
  - Last window = 72'h18_17_16_10_0F_0E_08_07_06.
  - `o_intr` high only with the 6th window.
- `IMG_WIDTH`=8, write pixels 1..32 continuously:
  - Second group of 6 windows starts after one bubble.
  - First window of that group = 72'h1B_1A_19_13_12_11_0B_0A_09.
  - Exactly 2 `o_intr` pulses total.
- Gapped input (valid every 3rd cycle), pixels 1..24: window values identical to the continuous case; no valid output before pixel 24 is stored.
- `IMG_WIDTH`=8, 80 pixels continuous:
  - Buffer index wraps (`rd_sel` 3→0).
  - Line 4's windows correctly use buffers 3, 0, 1, e.g. window 0 = 72'h2B_2A_29_23_22_21_1B_1A_19.
  - `total` never exceeds 32.
- Assert `rst` during the 3rd window of a line, then write 24 new pixels 101..124 → exactly 6 windows, first window built from 101..103 / 109..111 / 117..119; no stale data appears.
